jt51_timer_ctrl: RTL and testbench

- CPU-side controller for the JT51 timer pair: decodes the address/data write port, holds the CLKA/CLKB reload values and control bits, and drives load, clear-flag and IRQ-enable inputs of the timer block.
- Sequences CSM (composite sine mode) key-on bursts from timer A overflow.
- Generates the write-busy flag and assembles the status byte read by the CPU.
- Sits between the CPU bus interface and jt51_timers.

---
 rtl/jt51_timer_ctrl.sv | 158 +++++++++++++++
 tb/tb_jt51_timer_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl
// CPU-side controller for the JT51 timer pair. Decodes the two-step
// address/data write port, holds timer reload values and control bits,
// sequences CSM key-on bursts from timer A overflow, generates the
// write-busy flag and assembles the CPU status byte.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cen, zero         clock enable, sample-boundary strobe (valid with cen)
//   wr, a0, din       write strobe, address(0)/data(1) select, write data
//   flag_A, flag_B    timer flags from the timer block
//   overflow_A        timer A overflow from the timer block
//   value_A, value_B  timer reload values
//   load_A, load_B    timer run levels
//   clr_flag_A/B      one-clk flag clear pulses
//   enable_irq_A/B    timer IRQ enables
//   csm, csm_kon      CSM mode bit, CSM key-on request
//   busy, dout        write-busy flag, status byte {busy,5'b0,flag_B,flag_A}
module jt51_timer_ctrl #(
  parameter int BUSY_CYC = 32,
  parameter int KON_SMP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       csm,
  output logic       csm_kon,
  output logic       busy,
  output logic [7:0] dout
);

  localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYC);
  localparam logic [3:0] KON_LOAD  = 4'(KON_SMP);

  typedef enum logic {CSM_IDLE, CSM_ON} csm_state_t;

  logic [7:0] addr;
  logic [5:0] busy_cnt;
  logic [3:0] kon_cnt, kon_cnt_next;
  csm_state_t state, state_next;

  logic data_wr;
  assign data_wr = wr & a0;

  // Address latch and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= 8'd0;
      value_A      <= 10'd0;
      value_B      <= 8'd0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      csm          <= 1'b0;
    end else begin
      // Clear pulses last exactly one clk regardless of cen
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      if (wr && !a0) begin
        addr <= din;
      end else if (data_wr) begin
        case (addr)
          8'h10: value_A[9:2] <= din;
          8'h11: value_A[1:0] <= din[1:0];
          8'h12: value_B      <= din;
          8'h14: begin
            csm          <= din[7];
            clr_flag_B   <= din[5];
            clr_flag_A   <= din[4];
            enable_irq_B <= din[3];
            enable_irq_A <= din[2];
            load_B       <= din[1];
            load_A       <= din[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Busy counter: any data write (re)loads, otherwise count down on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 6'd0;
    end else if (data_wr) begin
      busy_cnt <= BUSY_LOAD;
    end else if (cen && busy_cnt != 6'd0) begin
      busy_cnt <= busy_cnt - 6'd1;
    end
  end

  assign busy = (busy_cnt != 6'd0);

  // CSM key-on FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CSM_IDLE;
      kon_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      kon_cnt <= kon_cnt_next;
    end
  end

  // CSM next-state logic; only advances on sample boundaries. A fresh
  // overflow while ON reloads the counter so the burst has no gap. The
  // csm bit only gates triggering, so clearing it never shortens a burst.
  always_comb begin
    state_next   = state;
    kon_cnt_next = kon_cnt;
    if (cen && zero) begin
      case (state)
        CSM_IDLE: begin
          if (overflow_A && csm) begin
            state_next   = CSM_ON;
            kon_cnt_next = KON_LOAD;
          end
        end
        CSM_ON: begin
          if (overflow_A && csm) begin
            kon_cnt_next = KON_LOAD;
          end else if (kon_cnt <= 4'd1) begin
            state_next   = CSM_IDLE;
            kon_cnt_next = 4'd0;
          end else begin
            kon_cnt_next = kon_cnt - 4'd1;
          end
        end
        default: begin
          state_next   = CSM_IDLE;
          kon_cnt_next = 4'd0;
        end
      endcase
    end
  end

  assign csm_kon = (state == CSM_ON);
  assign dout    = {busy, 5'b00000, flag_B, flag_A};

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
module tb_jt51_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0, zero = 1'b0, wr = 1'b0, a0 = 1'b0;
  logic [7:0] din = 8'd0;
  logic       flag_A = 1'b0, flag_B = 1'b0, overflow_A = 1'b0;

  logic [9:0] value_A, value_A_3;
  logic [7:0] value_B, value_B_3;
  logic load_A, load_B, clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B, csm, csm_kon, busy;
  logic load_A_3, load_B_3, clr_flag_A_3, clr_flag_B_3, enable_irq_A_3, enable_irq_B_3, csm_3, csm_kon_3, busy_3;
  logic [7:0] dout, dout_3;

  always #5 clk = ~clk;

  jt51_timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .wr(wr), .a0(a0), .din(din),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .csm(csm), .csm_kon(csm_kon), .busy(busy), .dout(dout)
  );

  jt51_timer_ctrl #(.BUSY_CYC(32), .KON_SMP(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .wr(wr), .a0(a0), .din(din),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .value_A(value_A_3), .value_B(value_B_3), .load_A(load_A_3), .load_B(load_B_3),
    .clr_flag_A(clr_flag_A_3), .clr_flag_B(clr_flag_B_3),
    .enable_irq_A(enable_irq_A_3), .enable_irq_B(enable_irq_B_3),
    .csm(csm_3), .csm_kon(csm_kon_3), .busy(busy_3), .dout(dout_3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: busy and key-on are "remaining time" counts
  logic [7:0] m_addr;
  logic [9:0] m_va;
  logic [7:0] m_vb;
  logic       m_csm, m_irqB, m_irqA, m_loadB, m_loadA, m_clrA, m_clrB;
  int         m_busy_left, m_kon1_left, m_kon3_left;

  task automatic model_reset();
    m_addr = 0; m_va = 0; m_vb = 0;
    m_csm = 0; m_irqB = 0; m_irqA = 0; m_loadB = 0; m_loadA = 0; m_clrA = 0; m_clrB = 0;
    m_busy_left = 0; m_kon1_left = 0; m_kon3_left = 0;
  endtask

  task automatic model_step();
    m_clrA = 0; m_clrB = 0;
    if (cen && zero) begin
      if (overflow_A && m_csm) begin
        m_kon1_left = 1;
        m_kon3_left = 3;
      end else begin
        if (m_kon1_left > 0) m_kon1_left--;
        if (m_kon3_left > 0) m_kon3_left--;
      end
    end
    if (wr && a0) m_busy_left = 32;
    else if (cen && m_busy_left > 0) m_busy_left--;
    if (wr && !a0) m_addr = din;
    else if (wr && a0) begin
      if (m_addr == 8'h10) m_va = {din, m_va[1:0]};
      else if (m_addr == 8'h11) m_va = {m_va[9:2], din[1:0]};
      else if (m_addr == 8'h12) m_vb = din;
      else if (m_addr == 8'h14) begin
        m_csm = din[7]; m_clrB = din[5]; m_clrA = din[4];
        m_irqB = din[3]; m_irqA = din[2]; m_loadB = din[1]; m_loadA = din[0];
      end
    end
  endtask

  task automatic chk_all();
    logic exp_busy;
    exp_busy = (m_busy_left > 0);
    chk("value_A", value_A, m_va);
    chk("value_B", value_B, m_vb);
    chk("ctrl", {csm, enable_irq_B, enable_irq_A, load_B, load_A}, {m_csm, m_irqB, m_irqA, m_loadB, m_loadA});
    chk("clr", {clr_flag_B, clr_flag_A}, {m_clrB, m_clrA});
    chk("busy", busy, exp_busy);
    chk("csm_kon", csm_kon, (m_kon1_left > 0));
    chk("csm_kon_3", csm_kon_3, (m_kon3_left > 0));
    chk("dout", dout, {exp_busy, 5'b00000, flag_B, flag_A});
  endtask

  task automatic cycle(input logic c, input logic z, input logic w, input logic a,
                       input logic [7:0] d, input logic o);
    @(negedge clk);
    cen = c; zero = z; wr = w; a0 = a; din = d; overflow_A = o;
    model_step();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic reg_write(input logic c, input logic [7:0] ad, input logic [7:0] d);
    cycle(c, 1'b0, 1'b1, 1'b0, ad, 1'b0);
    cycle(c, 1'b0, 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [9:0] va;
    logic [7:0] vb;
    logic [4:0] ctl;
    logic [1:0] clr;
  } vec_t;

  vec_t tbl[8];
  int   n, n1, n3;
  logic [7:0] addr_pick[6];

  initial begin
    tbl[0] = '{8'h10, 8'hAB, 10'h2AC, 8'h00, 5'h00, 2'b00};
    tbl[1] = '{8'h11, 8'hFE, 10'h2AE, 8'h00, 5'h00, 2'b00};
    tbl[2] = '{8'h12, 8'h5C, 10'h2AE, 8'h5C, 5'h00, 2'b00};
    tbl[3] = '{8'h14, 8'h3F, 10'h2AE, 8'h5C, 5'h0F, 2'b11};
    tbl[4] = '{8'h14, 8'h0F, 10'h2AE, 8'h5C, 5'h0F, 2'b00};
    tbl[5] = '{8'h13, 8'hFF, 10'h2AE, 8'h5C, 5'h0F, 2'b00};
    tbl[6] = '{8'h14, 8'h80, 10'h2AE, 8'h5C, 5'h10, 2'b00};
    tbl[7] = '{8'h14, 8'h00, 10'h2AE, 8'h5C, 5'h00, 2'b00};
    addr_pick = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h14, 8'h13};

    // Reset state
    model_reset();
    #12;
    chk_all();
    chk("reset_dout", dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Register decode table
    for (int i = 0; i < 8; i++) begin
      reg_write(1'b0, tbl[i].addr, tbl[i].data);
      chk("tbl_value_A", value_A, tbl[i].va);
      chk("tbl_value_B", value_B, tbl[i].vb);
      chk("tbl_ctrl", {csm, enable_irq_B, enable_irq_A, load_B, load_A}, tbl[i].ctl);
      chk("tbl_clr", {clr_flag_B, clr_flag_A}, tbl[i].clr);
      chk("tbl_busy", busy, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("tbl_clr_end", {clr_flag_B, clr_flag_A}, 2'b00);
      $display("table vector %0d: addr 0x%0h data 0x%0h -> value_A 0x%0h value_B 0x%0h", i, tbl[i].addr, tbl[i].data, value_A, value_B);
    end

    // Busy length, address-only write, reload while busy
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
    drain();
    chk("busy_drained", busy, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("addr_only_busy", busy, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    n = 1;
    while (busy && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (busy) n++;
    end
    chk("busy_len", n, 32);
    $display("busy single write: %0d clks", n);
    drain();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 19; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    n = 1;
    while (busy && n < 100) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (busy) n++;
    end
    chk("busy_reload_len", n, 32);
    $display("busy after reload: %0d clks", n);

    // CSM bursts: sample period 4 clks, overflow at samples 0 and 2
    reg_write(1'b0, 8'h14, 8'h80);
    n1 = 0; n3 = 0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        cycle(1'b1, (j == 0), 1'b0, 1'b0, 8'h00, (j == 0) && (k == 0 || k == 2));
        if (k == 0 && j == 0) chk("kon_start", csm_kon, 1'b1);
        if (k == 1 && j == 0) chk("kon1_end", csm_kon, 1'b0);
        if (csm_kon) n1++;
        if (csm_kon_3) n3++;
      end
    end
    chk("kon1_clks", n1, 8);
    chk("kon3_clks", n3, 20);
    $display("csm bursts: KON_SMP=1 %0d clks, KON_SMP=3 %0d clks", n1, n3);

    // csm=0: overflow ignored
    reg_write(1'b0, 8'h14, 8'h00);
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        cycle(1'b1, (j == 0), 1'b0, 1'b0, 8'h00, (j == 0));
        if (csm_kon || csm_kon_3) n1++;
      end
    end
    chk("kon_csm0", n1, 0);

    // Status byte
    drain();
    @(negedge clk);
    flag_A = 1'b1; flag_B = 1'b0;
    #1;
    chk("dout_flagA", dout, 8'h01);
    flag_B = 1'b1;
    reg_write(1'b0, 8'h20, 8'h00);
    chk("dout_busy_flags", dout, 8'h83);

    // Asynchronous reset mid-burst and mid-busy
    reg_write(1'b0, 8'h14, 8'h80);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_rst_kon", csm_kon_3, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_kon", csm_kon, 1'b0);
    chk("rst_kon_3", csm_kon_3, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_value_A", value_A, 10'd0);
    model_reset();
    chk_all();
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic c, z, w, a, o;
      logic [7:0] d;
      c = ($urandom_range(3) != 0);
      z = ($urandom_range(3) == 0);
      w = ($urandom_range(4) == 0);
      a = $urandom_range(1);
      o = ($urandom_range(2) == 0);
      d = w && !a ? addr_pick[$urandom_range(5)] : 8'($urandom);
      flag_A = $urandom_range(1);
      flag_B = $urandom_range(1);
      cycle(c, z, w, a, d, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
